pulse_voice_alloc: RTL and testbench

Polyphonic voice allocator and sequencer front-end for the bank of `pulse_channel` instances. It accepts key on/off events from the song player over a valid/ready handshake and assigns each note to a voice. Per voice it drives the `note_on`, `note_trigger` and `phase_inc` inputs of a `pulse_channel`. Sits between the pattern/song decoder and the pulse voices, in the same clock domain, using the shared `tick_clk`/`song_clk` strobes.

---
 rtl/pulse_voice_alloc.sv | 152 +++++++++++++++
 tb/tb_pulse_voice_alloc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_voice_alloc.sv
// pulse_voice_alloc: key on/off event allocator driving a bank of pulse_channel voices
module pulse_voice_alloc #(
  parameter int VOICES = 4,
  parameter int PHASE_BITS = 18,
  parameter int AGE_BITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick_clk,
  input  logic                         song_clk,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [6:0]                   ev_key,
  input  logic                         panic,
  output logic [VOICES-1:0]            voice_note_on,
  output logic [VOICES-1:0]            voice_trigger,
  output logic [VOICES*PHASE_BITS-1:0] voice_phase_inc
);
  localparam int IW = $clog2(VOICES);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2;
  localparam logic [14:0] BASE [16] = '{15'd11431, 15'd12110, 15'd12830, 15'd13593,
                                        15'd14402, 15'd15258, 15'd16165, 15'd17126,
                                        15'd18145, 15'd19224, 15'd20367, 15'd21578,
                                        15'd0, 15'd0, 15'd0, 15'd0};
  logic [1:0] state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, fm_q, fm_d, ff_q, ff_d, old_q, old_d, tgt;
  logic mf_q, mf_d, hf_q, hf_d, ev_on_q, ev_on_d, step;
  logic [6:0] ev_key_q, ev_key_d;
  logic [VOICES-1:0] mask_q, mask_d, on_q, on_d, trig_q, trig_d;
  logic [AGE_BITS-1:0] old_age_q, old_age_d;
  logic [VOICES-1:0][6:0] key_q, key_d;
  logic [VOICES-1:0][AGE_BITS-1:0] age_q, age_d;
  logic [VOICES-1:0][PHASE_BITS-1:0] ph_q, ph_d;
  logic [2:0] oct;
  logic [3:0] semi;
  logic [PHASE_BITS-1:0] ph_new;
  assign step = tick_clk & song_clk;
  assign oct = 3'(ev_key_q / 7'd12);
  assign semi = 4'(ev_key_q % 7'd12);
  assign ph_new = PHASE_BITS'(BASE[semi]) >> (3'd7 - oct);
  assign tgt = mf_q ? fm_q : hf_q ? ff_q : old_q;
  assign ev_ready = state_q == IDLE;
  assign voice_note_on = on_q;
  assign voice_trigger = trig_q;
  assign voice_phase_inc = ph_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    fm_d = fm_q;
    ff_d = ff_q;
    old_d = old_q;
    mf_d = mf_q;
    hf_d = hf_q;
    ev_on_d = ev_on_q;
    ev_key_d = ev_key_q;
    mask_d = mask_q;
    old_age_d = old_age_q;
    on_d = on_q;
    trig_d = trig_q;
    key_d = key_q;
    age_d = age_q;
    ph_d = ph_q;
    for (int i = 0; i < VOICES; i++) begin
      if (step) begin
        trig_d[i] = 1'b0;
        age_d[i] = &age_q[i] ? age_q[i] : age_q[i] + 1'b1;
      end
    end
    if (state_q == IDLE && ev_valid) begin
      state_d = SCAN;
      idx_d = '0;
      ev_on_d = ev_on;
      ev_key_d = ev_key;
      mask_d = '0;
      mf_d = 1'b0;
      hf_d = 1'b0;
    end else if (state_q == SCAN) begin
      if (on_q[idx_q] && key_q[idx_q] == ev_key_q) begin
        mask_d[idx_q] = 1'b1;
        if (!mf_q) begin
          mf_d = 1'b1;
          fm_d = idx_q;
        end
      end
      if (!on_q[idx_q] && !hf_q) begin
        hf_d = 1'b1;
        ff_d = idx_q;
      end
      if (idx_q == '0 || age_q[idx_q] > old_age_q) begin
        old_d = idx_q;
        old_age_d = age_q[idx_q];
      end
      idx_d = idx_q + 1'b1;
      if (idx_q == IW'(VOICES - 1)) state_d = COMMIT;
    end else if (state_q == COMMIT) begin
      state_d = IDLE;
      if (ev_key_q <= 7'd95) begin
        if (ev_on_q) begin
          key_d[tgt] = ev_key_q;
          on_d[tgt] = 1'b1;
          trig_d[tgt] = 1'b1;
          age_d[tgt] = '0;
          ph_d[tgt] = ph_new;
        end else begin
          on_d = on_q & ~mask_q;
        end
      end
    end
    if (panic) begin
      on_d = '0;
      trig_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      fm_q <= '0;
      ff_q <= '0;
      old_q <= '0;
      mf_q <= 1'b0;
      hf_q <= 1'b0;
      ev_on_q <= 1'b0;
      ev_key_q <= '0;
      mask_q <= '0;
      old_age_q <= '0;
      on_q <= '0;
      trig_q <= '0;
      key_q <= '0;
      age_q <= '0;
      ph_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      fm_q <= fm_d;
      ff_q <= ff_d;
      old_q <= old_d;
      mf_q <= mf_d;
      hf_q <= hf_d;
      ev_on_q <= ev_on_d;
      ev_key_q <= ev_key_d;
      mask_q <= mask_d;
      old_age_q <= old_age_d;
      on_q <= on_d;
      trig_q <= trig_d;
      key_q <= key_d;
      age_q <= age_d;
      ph_q <= ph_d;
    end
  end
endmodule

// File: tb/tb_pulse_voice_alloc.sv
// tb_pulse_voice_alloc: self-checking bench for pulse_voice_alloc
module tb_pulse_voice_alloc;
  localparam int V = 4, PB = 18;
  logic clk = 0, rst = 1, tick_clk = 0, song_clk = 0, ev_valid = 0, ev_on = 0, panic = 0;
  logic [6:0] ev_key = 0;
  logic ev_ready;
  logic [V-1:0] voice_note_on, voice_trigger;
  logic [V*PB-1:0] voice_phase_inc;
  int total = 0, bad = 0;
  int m_key[V], m_age[V], m_ph[V];
  bit m_on[V], m_trig[V];
  int base_tab[12] = '{11431, 12110, 12830, 13593, 14402, 15258, 16165, 17126, 18145, 19224, 20367, 21578};
  int rnd_keys[10] = '{60, 62, 64, 65, 67, 69, 71, 72, 100, 30};

  pulse_voice_alloc #(.VOICES(V), .PHASE_BITS(PB), .AGE_BITS(8)) dut (
    .clk(clk), .rst(rst), .tick_clk(tick_clk), .song_clk(song_clk),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on), .ev_key(ev_key),
    .panic(panic), .voice_note_on(voice_note_on), .voice_trigger(voice_trigger),
    .voice_phase_inc(voice_phase_inc));

  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < V; i++) begin
      m_key[i] = 0; m_age[i] = 0; m_ph[i] = 0; m_on[i] = 0; m_trig[i] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < V; i++) begin
      m_trig[i] = 0;
      if (m_age[i] < 255) m_age[i]++;
    end
  endfunction

  function automatic void model_event(bit on, int key);
    int t;
    if (key > 95) return;
    if (!on) begin
      for (int i = 0; i < V; i++) if (m_on[i] && m_key[i] == key) m_on[i] = 0;
      return;
    end
    t = -1;
    for (int i = 0; i < V; i++) if (t < 0 && m_on[i] && m_key[i] == key) t = i;
    for (int i = 0; i < V; i++) if (t < 0 && !m_on[i]) t = i;
    if (t < 0) begin
      t = 0;
      for (int i = 1; i < V; i++) if (m_age[i] > m_age[t]) t = i;
    end
    m_key[t] = key; m_on[t] = 1; m_trig[t] = 1; m_age[t] = 0;
    m_ph[t] = base_tab[key % 12] >> (7 - key / 12);
  endfunction

  task automatic do_step();
    tick_clk = 1; song_clk = 1;
    cyc();
    tick_clk = 0; song_clk = 0;
    model_step();
  endtask

  task automatic send(bit on, int key);
    ev_valid = 1; ev_on = on; ev_key = 7'(key);
    cyc();
    ev_valid = 0;
    repeat (V + 1) cyc();
    model_event(on, key);
  endtask

  task automatic do_reset();
    rst = 1;
    cyc();
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) cyc();
    rst = 0;
    model_reset();
    total++; if (ev_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ev_ready); end
    total++; if (voice_note_on !== '0) begin bad++; $display("FAIL reset_on got=%b want=0", voice_note_on); end
    total++; if (voice_trigger !== '0) begin bad++; $display("FAIL reset_trig got=%b want=0", voice_trigger); end
    total++; if (voice_phase_inc !== '0) begin bad++; $display("FAIL reset_phase got=%h want=0", voice_phase_inc); end
  endtask

  task automatic test_key_on();
    int n;
    ev_valid = 1; ev_on = 1; ev_key = 7'd69;
    cyc();
    ev_valid = 0;
    total++; if (ev_ready !== 1'b0) begin bad++; $display("FAIL keyon_ready_drop got=%b want=0", ev_ready); end
    n = 0;
    while (ev_ready !== 1'b1 && n < 20) begin
      total++; if (voice_note_on !== '0) begin bad++; $display("FAIL keyon_early got=%b want=0", voice_note_on); end
      cyc();
      n++;
    end
    total++; if (n != V + 1) begin bad++; $display("FAIL keyon_latency got=%0d want=%0d", n, V + 1); end
    model_event(1, 69);
    total++; if (voice_note_on !== 4'b0001) begin bad++; $display("FAIL keyon_on got=%b want=0001", voice_note_on); end
    total++; if (voice_trigger !== 4'b0001) begin bad++; $display("FAIL keyon_trig got=%b want=0001", voice_trigger); end
    total++; if (voice_phase_inc[0 +: PB] !== 18'd4806) begin bad++; $display("FAIL keyon_phase got=%0d want=4806", voice_phase_inc[0 +: PB]); end
    do_step();
    total++; if (voice_trigger !== 4'b0000) begin bad++; $display("FAIL keyon_trig_clear got=%b want=0000", voice_trigger); end
    total++; if (voice_note_on !== 4'b0001) begin bad++; $display("FAIL keyon_hold got=%b want=0001", voice_note_on); end
  endtask

  task automatic test_fill_and_steal();
    int keys[4] = '{60, 64, 67, 72};
    int phs[4] = '{2857, 3600, 4281, 5715};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send(1, keys[k]);
      repeat (3) do_step();
    end
    total++; if (voice_note_on !== 4'b1111) begin bad++; $display("FAIL fill_on got=%b want=1111", voice_note_on); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (voice_phase_inc[i*PB +: PB] !== 18'(phs[i])) begin
        bad++; $display("FAIL fill_phase%0d got=%0d want=%0d", i, voice_phase_inc[i*PB +: PB], phs[i]);
      end
    end
    send(1, 76);
    total++; if (voice_phase_inc[0 +: PB] !== 18'd7201) begin bad++; $display("FAIL steal_phase got=%0d want=7201", voice_phase_inc[0 +: PB]); end
    total++; if (voice_trigger !== 4'b0001) begin bad++; $display("FAIL steal_trig got=%b want=0001", voice_trigger); end
    total++; if (voice_phase_inc[PB +: PB] !== 18'd3600) begin bad++; $display("FAIL steal_other got=%0d want=3600", voice_phase_inc[PB +: PB]); end
  endtask

  task automatic test_retrigger();
    do_reset();
    send(1, 60);
    send(1, 64);
    do_step();
    send(1, 60);
    total++; if (voice_note_on !== 4'b0011) begin bad++; $display("FAIL retrig_on got=%b want=0011", voice_note_on); end
    total++; if (voice_trigger !== 4'b0001) begin bad++; $display("FAIL retrig_trig got=%b want=0001", voice_trigger); end
    total++; if (voice_phase_inc[PB +: PB] !== 18'd3600) begin bad++; $display("FAIL retrig_v1 got=%0d want=3600", voice_phase_inc[PB +: PB]); end
  endtask

  task automatic test_key_off();
    logic [V*PB-1:0] ph_snap;
    send(0, 64);
    total++; if (voice_note_on !== 4'b0001) begin bad++; $display("FAIL off_on got=%b want=0001", voice_note_on); end
    total++; if (voice_phase_inc[PB +: PB] !== 18'd3600) begin bad++; $display("FAIL off_keep_phase got=%0d want=3600", voice_phase_inc[PB +: PB]); end
    ph_snap = voice_phase_inc;
    send(0, 50);
    total++; if (voice_note_on !== 4'b0001) begin bad++; $display("FAIL off_nomatch got=%b want=0001", voice_note_on); end
    ev_valid = 1; ev_on = 1; ev_key = 7'd100;
    cyc();
    ev_valid = 0;
    total++; if (ev_ready !== 1'b0) begin bad++; $display("FAIL key100_accept got=%b want=0", ev_ready); end
    repeat (V + 1) cyc();
    total++; if (voice_note_on !== 4'b0001 || voice_trigger !== 4'b0001) begin bad++; $display("FAIL key100_on got=%b/%b want=0001/0001", voice_note_on, voice_trigger); end
    total++; if (voice_phase_inc !== ph_snap) begin bad++; $display("FAIL key100_phase got=%h want=%h", voice_phase_inc, ph_snap); end
  endtask

  task automatic test_collision();
    do_reset();
    ev_valid = 1; ev_on = 1; ev_key = 7'd60;
    cyc();
    ev_valid = 0;
    repeat (V) cyc();
    tick_clk = 1; song_clk = 1;
    cyc();
    tick_clk = 0; song_clk = 0;
    total++; if (voice_trigger !== 4'b0001) begin bad++; $display("FAIL collide_trig got=%b want=0001", voice_trigger); end
    total++; if (voice_note_on !== 4'b0001) begin bad++; $display("FAIL collide_on got=%b want=0001", voice_note_on); end
  endtask

  task automatic test_panic();
    do_reset();
    send(1, 60);
    send(1, 64);
    ev_valid = 1; ev_on = 1; ev_key = 7'd67;
    cyc();
    ev_valid = 0;
    cyc();
    panic = 1;
    cyc();
    panic = 0;
    total++; if (voice_note_on !== '0 || voice_trigger !== '0) begin bad++; $display("FAIL panic_clear got=%b/%b want=0000/0000", voice_note_on, voice_trigger); end
    repeat (3) cyc();
    total++; if (voice_note_on !== 4'b0100) begin bad++; $display("FAIL panic_commit_on got=%b want=0100", voice_note_on); end
    total++; if (voice_trigger !== 4'b0100) begin bad++; $display("FAIL panic_commit_trig got=%b want=0100", voice_trigger); end
    total++; if (voice_phase_inc[2*PB +: PB] !== 18'd4281) begin bad++; $display("FAIL panic_commit_phase got=%0d want=4281", voice_phase_inc[2*PB +: PB]); end
    total++; if (ev_ready !== 1'b1) begin bad++; $display("FAIL panic_ready got=%b want=1", ev_ready); end
  endtask

  task automatic test_rst_mid_scan();
    do_reset();
    send(1, 60);
    ev_valid = 1; ev_on = 1; ev_key = 7'd64;
    cyc();
    ev_valid = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    model_reset();
    total++; if (voice_note_on !== '0 || voice_trigger !== '0 || voice_phase_inc !== '0) begin bad++; $display("FAIL rst_mid_outputs got=%b/%b/%h want=0", voice_note_on, voice_trigger, voice_phase_inc); end
    total++; if (ev_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", ev_ready); end
    repeat (V + 2) cyc();
    total++; if (voice_note_on !== '0) begin bad++; $display("FAIL rst_mid_dropped got=%b want=0000", voice_note_on); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        panic = 1;
        cyc();
        panic = 0;
        for (int i = 0; i < V; i++) begin m_on[i] = 0; m_trig[i] = 0; end
      end else begin
        send($urandom_range(0, 99) < 65, rnd_keys[$urandom_range(0, 9)]);
      end
      repeat ($urandom_range(0, 3)) do_step();
      total++; if (ev_ready !== 1'b1) begin bad++; $display("FAIL rand_ready n=%0d got=%b want=1", n, ev_ready); end
      for (int i = 0; i < V; i++) begin
        total++;
        if (voice_note_on[i] !== m_on[i] || voice_trigger[i] !== m_trig[i] || voice_phase_inc[i*PB +: PB] !== 18'(m_ph[i])) begin
          bad++;
          $display("FAIL rand_voice n=%0d v=%0d got=%b/%b/%0d want=%b/%b/%0d", n, i,
                   voice_note_on[i], voice_trigger[i], voice_phase_inc[i*PB +: PB], m_on[i], m_trig[i], m_ph[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_key_on();
    test_fill_and_steal();
    test_retrigger();
    test_key_off();
    test_collision();
    test_panic();
    test_rst_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
